// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared register-index type and forwarding-select constants
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
  localparam int FWD_REG_FILE = 0;
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: decode-side bundle of the forwarding/hazard unit
// fu: rs, rs_use, dec_valid, dec_wen, dec_rd, dec_lat, flush, mem_stall in; dec_ready, fwd_sel, stall_cnt out
// tb: the mirror image, for whoever drives decode
interface fwd_hazard_unit_if #(
  parameter int NRD = 2,
  parameter int NFWD = 3,
  parameter int MAXLAT = 3,
  parameter int CNTW = 32
);
  import cpu_types_pkg::*;
  localparam int SELW = $clog2(NFWD + 1);
  localparam int LATW = $clog2(MAXLAT + 1);
  regbits_t [NRD-1:0] rs;
  logic [NRD-1:0] rs_use;
  logic dec_valid;
  logic dec_wen;
  regbits_t dec_rd;
  logic [LATW-1:0] dec_lat;
  logic flush;
  logic mem_stall;
  logic dec_ready;
  logic [NRD-1:0][SELW-1:0] fwd_sel;
  logic [CNTW-1:0] stall_cnt;
  modport fu(
    input rs, rs_use, dec_valid, dec_wen, dec_rd, dec_lat, flush, mem_stall,
    output dec_ready, fwd_sel, stall_cnt
  );
  modport tb(
    output rs, rs_use, dec_valid, dec_wen, dec_rd, dec_lat, flush, mem_stall,
    input dec_ready, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_port_match.sv
// fwd_port_match: priority-match one read port against the in-flight entries
// in: entValid/entRd/entRem per stage, rs, rsUse; out: stage (youngest match), hit, hazard (match not yet forwardable)
module fwd_port_match
  import cpu_types_pkg::*;
#(
  parameter int NFWD = 3,
  parameter int LATW = 2,
  parameter int IDXW = 2
) (
  input  logic [NFWD-1:0]           entValid,
  input  regbits_t [NFWD-1:0]       entRd,
  input  logic [NFWD-1:0][LATW-1:0] entRem,
  input  regbits_t                  rs,
  input  logic                      rsUse,
  output logic [IDXW-1:0]           stage,
  output logic                      hit,
  output logic                      hazard
);
  // scan oldest to youngest so the youngest match is the last one written
  always_comb begin
    hit = 1'b0;
    stage = '0;
    hazard = 1'b0;
    for (int s = NFWD - 1; s >= 0; s--)
      if (rsUse && rs != '0 && entValid[s] && entRd[s] == rs) begin
        hit = 1'b1;
        stage = IDXW'(s);
        hazard = entRem[s] != '0;
      end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight writes, selects forwarding sources, stalls issue on unready results
// CLK, RST (async, active-high); bus (fu modport): decode read ports and issue handshake in,
// dec_ready, per-port fwd_sel (0 = register file, s+1 = stage s) and saturating stall_cnt out
module fwd_hazard_unit
  import cpu_types_pkg::*;
#(
  parameter int NRD = 2,
  parameter int NFWD = 3,
  parameter int MAXLAT = 3,
  parameter int CNTW = 32
) (
  input logic CLK,
  input logic RST,
  fwd_hazard_unit_if.fu bus
);
  localparam int LATW = $clog2(MAXLAT + 1);
  localparam int SELW = $clog2(NFWD + 1);
  typedef struct packed {
    logic valid;
    regbits_t rd;
    logic [LATW-1:0] rem;
  } entry_t;
  entry_t [NFWD-1:0] ent;
  logic [NFWD-1:0] entValid;
  regbits_t [NFWD-1:0] entRd;
  logic [NFWD-1:0][LATW-1:0] entRem;
  logic [NRD-1:0] hit, hazard;
  logic [NRD-1:0][SELW-1:0] stage, fwdSel;
  logic [CNTW-1:0] stallCnt;
  logic ready, issue;
  for (genvar s = 0; s < NFWD; s++) begin : g_ent
    assign entValid[s] = ent[s].valid;
    assign entRd[s] = ent[s].rd;
    assign entRem[s] = ent[s].rem;
  end
  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_port_match #(.NFWD(NFWD), .LATW(LATW), .IDXW(SELW)) u_match (
      .entValid(entValid),
      .entRd(entRd),
      .entRem(entRem),
      .rs(bus.rs[p]),
      .rsUse(bus.rs_use[p]),
      .stage(stage[p]),
      .hit(hit[p]),
      .hazard(hazard[p])
    );
    assign fwdSel[p] = hit[p] && !hazard[p] ? stage[p] + SELW'(1) : SELW'(FWD_REG_FILE);
  end
  assign ready = !bus.mem_stall && !(|hazard);
  assign issue = bus.dec_valid && ready && !bus.flush;
  assign bus.dec_ready = ready;
  assign bus.fwd_sel = fwdSel;
  assign bus.stall_cnt = stallCnt;
  // the freshly inserted entry already carries lat-1; only shifted entries count down
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ent <= '0;
      stallCnt <= '0;
    end else begin
      if (!bus.mem_stall) begin
        for (int s = NFWD - 1; s > 0; s--)
          ent[s] <= entry_t'{ent[s-1].valid, ent[s-1].rd, ent[s-1].rem - LATW'(ent[s-1].rem != '0)};
        ent[0] <= issue ? entry_t'{bus.dec_wen, bus.dec_rd, bus.dec_lat - LATW'(1)} : '0;
      end else if (bus.flush)
        ent[0].valid <= 1'b0;
      if (bus.dec_valid && !ready && !bus.flush && stallCnt != '1)
        stallCnt <= stallCnt + CNTW'(1);
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scenario tasks with a scoreboard of expected outputs per driven cycle
module tb_fwd_hazard_unit;
  typedef struct packed {
    logic [4:0] rs0, rs1;
    logic [1:0] ru;
    logic v, w;
    logic [4:0] rd;
    logic [1:0] lat;
    logic fl, ms;
    logic [1:0] s0, s1;
    logic rdy;
    logic [31:0] cnt;
  } row_t;
  typedef struct packed {
    logic [1:0] s0, s1;
    logic rdy;
    logic [31:0] cnt;
  } exp_t;

  logic CLK, RST;
  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];

  fwd_hazard_unit_if i1 ();
  fwd_hazard_unit_if #(.CNTW(4)) i2 ();
  fwd_hazard_unit dut (.CLK(CLK), .RST(RST), .bus(i1));
  fwd_hazard_unit #(.CNTW(4)) dutSat (.CLK(CLK), .RST(RST), .bus(i2));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK)
    if (!RST && i1.dec_valid && i1.dec_ready && !i1.flush)
      assert (i1.dec_lat inside {[1:3]}) else $error("illegal dec_lat %0d", i1.dec_lat);

  function automatic row_t r(input int rs0, rs1, ru, v, w, rd, lat, fl, ms, s0, s1, rdy, cnt);
    r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.ru = 2'(ru); r.v = 1'(v); r.w = 1'(w);
    r.rd = 5'(rd); r.lat = 2'(lat); r.fl = 1'(fl); r.ms = 1'(ms);
    r.s0 = 2'(s0); r.s1 = 2'(s1); r.rdy = 1'(rdy); r.cnt = 32'(cnt);
  endfunction

  task automatic apply(input row_t x);
    i1.rs[0] = x.rs0; i1.rs[1] = x.rs1; i1.rs_use = x.ru;
    i1.dec_valid = x.v; i1.dec_wen = x.w; i1.dec_rd = x.rd; i1.dec_lat = x.lat;
    i1.flush = x.fl; i1.mem_stall = x.ms;
    sb.push_back(exp_t'{x.s0, x.s1, x.rdy, x.cnt});
  endtask

  task automatic rst_pulse();
    apply(r(0,0,0,0,0,0,1,0,0,0,0,1,0));
    void'(sb.pop_back());
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, got;
    RST = 1'b1;
    @(negedge CLK);
    apply(r(0,0,0,0,0,0,1,0,1,0,0,0,0));
    #1;
    e = sb.pop_front();
    got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL reset_ms: got %h want %h", got, e);
    end
    apply(r(0,0,0,0,0,0,1,0,0,0,0,1,0));
    #1;
    e = sb.pop_front();
    got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL reset_idle: got %h want %h", got, e);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e, got;
    rst_pulse();
    rows.push_back(r(0,0,0,1,1,8,1,0,0,0,0,1,0));
    rows.push_back(r(8,0,1,0,0,0,1,0,0,1,0,1,0));
    rows.push_back(r(0,8,2,0,0,0,1,0,0,0,2,1,0));
    rows.push_back(r(8,0,1,0,0,0,1,0,0,3,0,1,0));
    rows.push_back(r(8,8,3,0,0,0,1,0,0,0,0,1,0));
    foreach (rows[i]) begin
      @(negedge CLK);
      apply(rows[i]);
      #1;
      e = sb.pop_front();
      got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL b2b row%0d: got sel=%0d/%0d rdy=%b cnt=%0d want sel=%0d/%0d rdy=%b cnt=%0d",
                 i, got.s0, got.s1, got.rdy, got.cnt, e.s0, e.s1, e.rdy, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e, got;
    rst_pulse();
    rows.push_back(r(0,0,0,1,1,9,2,0,0,0,0,1,0));
    rows.push_back(r(9,0,1,1,1,10,1,0,0,0,0,0,0));
    rows.push_back(r(9,0,1,1,1,10,1,0,0,2,0,1,1));
    rows.push_back(r(10,0,1,0,0,0,1,0,0,1,0,1,1));
    foreach (rows[i]) begin
      @(negedge CLK);
      apply(rows[i]);
      #1;
      e = sb.pop_front();
      got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL load_use row%0d: got sel=%0d/%0d rdy=%b cnt=%0d want sel=%0d/%0d rdy=%b cnt=%0d",
                 i, got.s0, got.s1, got.rdy, got.cnt, e.s0, e.s1, e.rdy, e.cnt);
      end
    end
  endtask

  task automatic test_youngest();
    row_t rows[$];
    exp_t e, got;
    rst_pulse();
    rows.push_back(r(0,0,0,1,1,5,1,0,0,0,0,1,0));
    rows.push_back(r(0,0,0,0,0,0,1,0,0,0,0,1,0));
    rows.push_back(r(0,0,0,1,1,5,1,0,0,0,0,1,0));
    rows.push_back(r(5,0,3,0,0,0,1,0,0,1,0,1,0));
    rows.push_back(r(5,0,1,1,1,5,3,0,0,2,0,1,0));
    rows.push_back(r(5,0,1,0,0,0,1,0,0,0,0,0,0));
    rows.push_back(r(0,0,0,1,0,6,1,0,0,0,0,1,0));
    rows.push_back(r(6,0,1,0,0,0,1,0,0,0,0,1,0));
    foreach (rows[i]) begin
      @(negedge CLK);
      apply(rows[i]);
      #1;
      e = sb.pop_front();
      got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL youngest row%0d: got sel=%0d/%0d rdy=%b cnt=%0d want sel=%0d/%0d rdy=%b cnt=%0d",
                 i, got.s0, got.s1, got.rdy, got.cnt, e.s0, e.s1, e.rdy, e.cnt);
      end
    end
  endtask

  task automatic test_mem_stall();
    row_t rows[$];
    exp_t e, got;
    rst_pulse();
    rows.push_back(r(0,0,0,1,1,7,3,0,0,0,0,1,0));
    rows.push_back(r(7,0,1,1,1,11,1,0,1,0,0,0,0));
    rows.push_back(r(7,0,1,1,1,11,1,0,1,0,0,0,1));
    rows.push_back(r(7,0,1,1,1,11,1,0,1,0,0,0,2));
    rows.push_back(r(7,0,1,1,1,11,1,0,0,0,0,0,3));
    rows.push_back(r(7,0,1,1,1,11,1,0,0,0,0,0,4));
    rows.push_back(r(7,0,1,1,1,11,1,0,0,3,0,1,5));
    rows.push_back(r(11,0,1,0,0,0,1,0,0,1,0,1,5));
    foreach (rows[i]) begin
      @(negedge CLK);
      apply(rows[i]);
      #1;
      e = sb.pop_front();
      got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL mem_stall row%0d: got sel=%0d/%0d rdy=%b cnt=%0d want sel=%0d/%0d rdy=%b cnt=%0d",
                 i, got.s0, got.s1, got.rdy, got.cnt, e.s0, e.s1, e.rdy, e.cnt);
      end
    end
  endtask

  task automatic test_flush_retire();
    row_t rows[$];
    exp_t e, got;
    rst_pulse();
    rows.push_back(r(0,0,0,1,1,12,2,1,0,0,0,1,0));
    rows.push_back(r(12,0,1,0,0,0,1,0,0,0,0,1,0));
    rows.push_back(r(0,0,0,1,1,13,1,0,0,0,0,1,0));
    rows.push_back(r(13,0,1,0,0,0,1,1,1,1,0,0,0));
    rows.push_back(r(13,0,1,0,0,0,1,0,0,0,0,1,0));
    rows.push_back(r(0,0,0,1,1,3,1,1,1,0,0,0,0));
    rows.push_back(r(0,0,0,0,0,0,1,0,0,0,0,1,0));
    rows.push_back(r(0,0,0,1,1,14,1,0,0,0,0,1,0));
    rows.push_back(r(14,0,1,0,0,0,1,0,0,1,0,1,0));
    rows.push_back(r(14,0,1,0,0,0,1,0,0,2,0,1,0));
    rows.push_back(r(0,14,2,0,0,0,1,0,0,0,3,1,0));
    rows.push_back(r(14,14,3,0,0,0,1,0,0,0,0,1,0));
    foreach (rows[i]) begin
      @(negedge CLK);
      apply(rows[i]);
      #1;
      e = sb.pop_front();
      got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL flush_retire row%0d: got sel=%0d/%0d rdy=%b cnt=%0d want sel=%0d/%0d rdy=%b cnt=%0d",
                 i, got.s0, got.s1, got.rdy, got.cnt, e.s0, e.s1, e.rdy, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    row_t rows[$];
    exp_t e, got;
    rst_pulse();
    rows.push_back(r(0,0,0,1,1,9,3,0,0,0,0,1,0));
    rows.push_back(r(9,0,1,1,1,10,1,0,0,0,0,0,0));
    rows.push_back(r(9,0,1,1,1,10,1,0,0,0,0,0,1));
    foreach (rows[i]) begin
      @(negedge CLK);
      apply(rows[i]);
      #1;
      e = sb.pop_front();
      got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL rst_mid row%0d: got sel=%0d/%0d rdy=%b cnt=%0d want sel=%0d/%0d rdy=%b cnt=%0d",
                 i, got.s0, got.s1, got.rdy, got.cnt, e.s0, e.s1, e.rdy, e.cnt);
      end
    end
    RST = 1'b1;
    sb.push_back(exp_t'{2'd0, 2'd0, 1'b1, 32'd0});
    #1;
    e = sb.pop_front();
    got = {i1.fwd_sel[0], i1.fwd_sel[1], i1.dec_ready, i1.stall_cnt};
    compared++;
    if (got !== e) begin
      mismatched++;
      $display("FAIL rst_mid async: got sel=%0d/%0d rdy=%b cnt=%0d want sel=0/0 rdy=1 cnt=0",
               got.s0, got.s1, got.rdy, got.cnt);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_saturate();
    logic [3:0] want[$];
    logic [3:0] w;
    rst_pulse();
    @(negedge CLK);
    i2.dec_valid = 1'b1;
    i2.mem_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      want.push_back(k == 0 ? 4'd10 : 4'd15);
      repeat (10) @(negedge CLK);
      #1;
      w = want.pop_front();
      compared++;
      if (i2.stall_cnt !== w) begin
        mismatched++;
        $display("FAIL saturate step%0d: got cnt=%0d want cnt=%0d", k, i2.stall_cnt, w);
      end
    end
    i2.dec_valid = 1'b0;
    i2.mem_stall = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    i2.rs = '0; i2.rs_use = '0; i2.dec_valid = 1'b0; i2.dec_wen = 1'b0;
    i2.dec_rd = '0; i2.dec_lat = 2'd1; i2.flush = 1'b0; i2.mem_stall = 1'b0;
    apply(r(0,0,0,0,0,0,1,0,0,0,0,1,0));
    void'(sb.pop_back());
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_mem_stall();
    test_flush_retire();
    test_reset_mid_stall();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
